dmem_arbiter: RTL

Two-port arbiter and access sequencer for the single-port data memory. It shares the memory between requester 0 (CPU load/store stage) and requester 1 (DMA/debug loader). It runs each transaction through a fixed issue/response sequence and handles the memory's one-cycle registered read latency. Requests whose word index is outside the memory are rejected without touching the memory.

---
 rtl/dmem_arb_pkg.sv | 15 +
 rtl/dmem_arb_pick.sv | 29 ++
 rtl/dmem_arbiter.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_arb_pkg;

  localparam int DATA_W = 32;

  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_DMA = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

endpackage

// File: rtl/dmem_arb_pick.sv
// Combinational winner select between the CPU and DMA requesters.
// DMEM_ARB_RR_EN selects round-robin on ties; otherwise the CPU always wins.
module dmem_arb_pick
  import dmem_arb_pkg::*;
(
  input  logic r0_req,
  input  logic r1_req,
`ifdef DMEM_ARB_RR_EN
  input  logic last_grant,
`endif
  output logic grant_valid,
  output logic grant_id
);

  always_comb begin
    grant_valid = r0_req | r1_req;
    grant_id    = REQ_CPU;
    if (r0_req && r1_req) begin
`ifdef DMEM_ARB_RR_EN
      grant_id = ~last_grant;
`else
      grant_id = REQ_CPU;
`endif
    end else if (r1_req) begin
      grant_id = REQ_DMA;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter and IDLE/ACCESS/RESP sequencer for the single-port data memory.
// Define DMEM_ARB_RR_EN for round-robin arbitration (default: fixed priority, r0 first).
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int MEM_WORDS = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              r0_req,
  input  logic              r0_we,
  input  logic [DATA_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  output logic              r0_ack,
  output logic              r0_err,
  output logic [DATA_W-1:0] r0_rdata,
  input  logic              r1_req,
  input  logic              r1_we,
  input  logic [DATA_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              r1_ack,
  output logic              r1_err,
  output logic [DATA_W-1:0] r1_rdata,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam logic [DATA_W-1:0] MEM_LIMIT = DATA_W'(MEM_WORDS);

  state_e            state_q, state_d;
  logic              id_q, id_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic              r0_ack_q, r0_ack_d;
  logic              r1_ack_q, r1_ack_d;
  logic              r0_err_q, r0_err_d;
  logic              r1_err_q, r1_err_d;
  logic              busy_q, busy_d;
`ifdef DMEM_ARB_RR_EN
  logic              last_q, last_d;
`endif

  logic              grant_valid;
  logic              grant_id;
  logic              sel_we;
  logic [DATA_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              sel_in_range;

  dmem_arb_pick u_pick (
    .r0_req      (r0_req),
    .r1_req      (r1_req),
`ifdef DMEM_ARB_RR_EN
    .last_grant  (last_q),
`endif
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  assign sel_we       = (grant_id == REQ_DMA) ? r1_we    : r0_we;
  assign sel_addr     = (grant_id == REQ_DMA) ? r1_addr  : r0_addr;
  assign sel_wdata    = (grant_id == REQ_DMA) ? r1_wdata : r0_wdata;
  assign sel_in_range = sel_addr < MEM_LIMIT;

  // Memory strobes and acks are computed one state early so every output leaves a flop.
  always_comb begin
    state_d     = state_q;
    id_d        = id_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    mem_read_d  = 1'b0;
    mem_write_d = 1'b0;
    r0_ack_d    = 1'b0;
    r1_ack_d    = 1'b0;
    r0_err_d    = 1'b0;
    r1_err_d    = 1'b0;
`ifdef DMEM_ARB_RR_EN
    last_d      = last_q;
`endif
    case (state_q)
      IDLE: begin
        if (grant_valid) begin
          id_d    = grant_id;
          we_d    = sel_we;
          addr_d  = sel_addr;
          wdata_d = sel_wdata;
`ifdef DMEM_ARB_RR_EN
          last_d  = grant_id;
`endif
          if (sel_in_range) begin
            state_d     = ACCESS;
            mem_read_d  = ~sel_we;
            mem_write_d = sel_we;
          end else begin
            state_d  = RESP;
            r0_ack_d = (grant_id == REQ_CPU);
            r1_ack_d = (grant_id == REQ_DMA);
            r0_err_d = (grant_id == REQ_CPU);
            r1_err_d = (grant_id == REQ_DMA);
          end
        end
      end
      ACCESS: begin
        state_d  = RESP;
        r0_ack_d = (id_q == REQ_CPU);
        r1_ack_d = (id_q == REQ_DMA);
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      id_q        <= REQ_CPU;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      r0_ack_q    <= 1'b0;
      r1_ack_q    <= 1'b0;
      r0_err_q    <= 1'b0;
      r1_err_q    <= 1'b0;
      busy_q      <= 1'b0;
`ifdef DMEM_ARB_RR_EN
      last_q      <= REQ_DMA;
`endif
    end else begin
      state_q     <= state_d;
      id_q        <= id_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      r0_ack_q    <= r0_ack_d;
      r1_ack_q    <= r1_ack_d;
      r0_err_q    <= r0_err_d;
      r1_err_q    <= r1_err_d;
      busy_q      <= busy_d;
`ifdef DMEM_ARB_RR_EN
      last_q      <= last_d;
`endif
    end
  end

  // mem_rdata is registered in the memory, so it lines up with the RESP-cycle ack.
  assign r0_rdata  = (r0_ack_q && !we_q && !r0_err_q) ? mem_rdata : '0;
  assign r1_rdata  = (r1_ack_q && !we_q && !r1_err_q) ? mem_rdata : '0;

  assign r0_ack    = r0_ack_q;
  assign r1_ack    = r1_ack_q;
  assign r0_err    = r0_err_q;
  assign r1_err    = r1_err_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign busy      = busy_q;

endmodule
